// File: rtl/sede_pkg.sv
// Shared constants and types for the edge-detection datapath (feeder and engine).
package sede_pkg;

    localparam int unsigned IMG_W     = 32;
    localparam int unsigned IMG_H     = 32;
    localparam int unsigned PIX_W     = 8;
    localparam int unsigned FRAME_PIX = IMG_W * IMG_H;
    localparam int unsigned ADDR_W    = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } feed_state_e;

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry FIFO between the image-memory read port and the edge engine.
// The head is presented combinationally; dout reads 0 while empty.
module pix_skid_fifo #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slots [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Qualify push/pop against occupancy and drive the head.
    always_comb begin
        do_pop  = pop && (count != 2'd0);
        do_push = push && ((count != 2'd2) || do_pop);
        empty   = (count == 2'd0);
        dout    = empty ? '0 : slots[rd_ptr];
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Data storage needs no reset: nothing is visible until the slot is written.
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= din;
    end

endmodule

// File: rtl/pix_feeder.sv
// Streams one image from memory to the edge engine in raster order.
// Reads are issued only when the FIFO is guaranteed a free slot on return,
// so backpressure can never overflow the two-entry buffer.
module pix_feeder #(
    parameter int unsigned IMG_W = sede_pkg::IMG_W,
    parameter int unsigned IMG_H = sede_pkg::IMG_H,
    parameter int unsigned PIX_W = sede_pkg::PIX_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        mem_rd,
    output logic [sede_pkg::ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]            mem_rdata,
    input  logic                        eng_busy,
    output logic                        pix_valid,
    output logic [PIX_W-1:0]            pix_data,
    output logic                        feeding,
    output logic                        done
);

    import sede_pkg::*;

    localparam int unsigned FRAME = IMG_W * IMG_H;
    localparam int unsigned CNT_W = $clog2(FRAME + 1);

    feed_state_e      state;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] tx_cnt;
    logic             in_flight;

    logic             fifo_empty;
    logic [1:0]       fifo_count;
    logic [PIX_W-1:0] fifo_dout;

    logic             accept;
    logic             reads_left;
    logic [2:0]       occupancy;
    logic             rd_req;
    logic             last_beat;

    // Read issue, beat acceptance and end-of-frame detection.
    always_comb begin
        accept     = !fifo_empty && !eng_busy;
        reads_left = (rd_cnt < CNT_W'(FRAME));
        // Slots committed after this edge: stored + returning - leaving.
        occupancy  = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, accept};
        rd_req     = (state == RUN) && reads_left && (occupancy < 3'd2);
        last_beat  = (state == RUN) && accept && (tx_cnt == CNT_W'(FRAME - 1));
        mem_rd     = rd_req;
        mem_addr   = rd_req ? ADDR_W'(rd_cnt) : '0;
        pix_valid  = !fifo_empty;
        pix_data   = fifo_dout;
    end

    // Frame FSM with counters and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            tx_cnt    <= '0;
            in_flight <= 1'b0;
            feeding   <= 1'b0;
            done      <= 1'b0;
        end else begin
            // A read issued now returns data next cycle.
            in_flight <= rd_req;
            if (rd_req) rd_cnt <= rd_cnt + 1'b1;
            unique case (state)
                IDLE: begin
                    tx_cnt <= '0;
                    done   <= 1'b0;
                    if (start) begin
                        state   <= RUN;
                        rd_cnt  <= '0;
                        feeding <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) tx_cnt <= tx_cnt + 1'b1;
                    if (last_beat) begin
                        state   <= DONE;
                        feeding <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done   <= 1'b0;
                    tx_cnt <= '0;
                end
                default: begin
                    state   <= IDLE;
                    feeding <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    pix_skid_fifo #(
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_flight),
        .pop   (accept),
        .din   (mem_rdata),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_pix_feeder.sv
// Scoreboard bench for pix_feeder: stimulus queues expected pixels, a monitor
// pops and compares every accepted beat and checks timing/hold behaviour.
module tb_pix_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mem_rd;
    logic [9:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       eng_busy;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       feeding;
    logic       done;

    pix_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .eng_busy  (eng_busy),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .feeding   (feeding),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Image memory: Memory[a] = a mod 256, one-cycle read latency, garbage otherwise.
    always @(posedge clk) mem_rdata <= mem_rd ? mem_addr[7:0] : 8'hA5;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    int         start_cyc = 0;
    int         exp_done_rel = -1;
    int         done_cnt = 0;
    bit         first_pend = 1'b0;
    int         busy_mode = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Backpressure driver: 0 = never busy, 1 = busy in relative cycles 10..19, 2 = random.
    initial begin
        eng_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (busy_mode)
                1:       eng_busy = (cyc - start_cyc >= 10) && (cyc - start_cyc <= 19);
                2:       eng_busy = 1'($urandom_range(0, 1));
                default: eng_busy = 1'b0;
            endcase
        end
    end

    // Monitor: compares accepted beats against the scoreboard and checks invariants.
    initial begin
        bit         prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                check("hold_valid", int'(pix_valid), 1);
                check("hold_data", int'(pix_data), int'(prev_data));
            end
            if (pix_valid && first_pend) begin
                check("first_beat_cycle", cyc - start_cyc, 3);
                first_pend = 1'b0;
            end
            if (!pix_valid) begin
                check("idle_data_known", int'($isunknown(pix_data)), 0);
                check("idle_data_zero", int'(pix_data), 0);
            end
            if (pix_valid && !eng_busy) begin
                check("beat_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("beat_data", int'(pix_data), int'(exp_q.pop_front()));
            end
            check("fifo_count_le2", int'(dut.u_fifo.count <= 2'd2), 1);
            if (done) begin
                done_cnt++;
                check("done_feeding_low", int'(feeding), 0);
                if (exp_done_rel >= 0) check("done_cycle", cyc - start_cyc, exp_done_rel);
            end
            prev_stall = pix_valid && eng_busy;
            prev_data  = pix_data;
        end
    end

    // Called at posedge+1: queue a full frame's expectations and pulse start.
    task automatic start_frame(input int mode, input int done_rel);
        busy_mode    = mode;
        exp_done_rel = done_rel;
        start_cyc    = cyc;
        first_pend   = 1'b1;
        for (int i = 0; i < 1024; i++) exp_q.push_back(8'(i));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        bit seen;
        int n;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < max_cycles) begin
            @(negedge clk);
            seen = done;
            n++;
        end
        check("done_seen", int'(seen), 1);
    endtask

    task automatic end_checks(input int exp_dones);
        check("scoreboard_drained", exp_q.size(), 0);
        check("done_pulses", done_cnt, exp_dones);
    endtask

    task automatic check_reset_outputs();
        check("rst_mem_rd", int'(mem_rd), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_pix_valid", int'(pix_valid), 0);
        check("rst_pix_data", int'(pix_data), 0);
        check("rst_feeding", int'(feeding), 0);
        check("rst_done", int'(done), 0);
    endtask

    initial begin
        int saved_dones;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Free-running frame.
        start_frame(0, 1027);
        wait_done(3000);
        end_checks(1);
        @(posedge clk); #1;

        // Ten cycles of backpressure delay done by ten cycles.
        start_frame(1, 1037);
        wait_done(3000);
        end_checks(2);
        @(posedge clk); #1;

        // Random backpressure.
        start_frame(2, -1);
        wait_done(5000);
        busy_mode = 0;
        end_checks(3);
        @(posedge clk); #1;

        // start re-pulsed mid-frame must be ignored.
        start_frame(0, 1027);
        repeat (99) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(3000);
        end_checks(4);
        @(posedge clk); #1;

        // Reset mid-frame aborts without done; next start gives a full frame.
        start_frame(0, 1027);
        repeat (499) begin @(posedge clk); #1; end
        saved_dones = done_cnt;
        rst = 1'b1;
        exp_q.delete();
        first_pend = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        check("no_done_after_abort", done_cnt, saved_dones);
        start_frame(0, 1027);
        wait_done(3000);
        end_checks(5);

        // Back-to-back: start in the cycle after done.
        @(posedge clk); #1;
        start_frame(0, 1027);
        wait_done(3000);
        end_checks(6);
        @(posedge clk); #1;
        check("gap_feeding_low", int'(feeding), 0);
        start_frame(0, 1027);
        wait_done(3000);
        end_checks(7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/pix_feeder.md
PIX_FEEDER -- requirements
Module: pix_feeder

Interface
REQ-001 Parameter IMG_W, 32, pixels per image row.
REQ-002 Parameter IMG_H, 32, rows per image.
REQ-003 Parameter PIX_W, 8, pixel width in bits.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle request to stream one full image.
REQ-007 mem_rd  out  1  image-memory read strobe.
REQ-008 mem_addr  out  10  raster read address (y*IMG_W+x), valid while mem_rd=1.
REQ-009 mem_rdata  in  PIX_W  read data, valid exactly 1 cycle after mem_rd.
REQ-010 eng_busy  in  1  edge-engine backpressure; 1 = beat not accepted.
REQ-011 pix_valid  out  1  pix_data holds a pixel for the edge engine.
REQ-012 pix_data  out  PIX_W  pixel to edge engine, raster order, x fastest.
REQ-013 feeding  out  1  high from the first cycle after an accepted start until done.
REQ-014 done  out  1  one-cycle pulse after last pixel accepted.

Function
REQ-015 Beat accepted SHALL be defined as pix_valid=1 and eng_busy=0 in the same cycle.
REQ-016 FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-017 IDLE->RUN on start=1; RUN->DONE on the cycle the IMG_W*IMG_H-th beat is accepted; DONE->IDLE unconditionally after 1 cycle.
REQ-018 start SHALL be ignored in RUN and DONE.
REQ-019 done=1 only in DONE; feeding=1 only in RUN.
REQ-020 Read counter SHALL issue addresses 0..IMG_W*IMG_H-1 exactly once each, in increasing order, with no wrap within a frame; it SHALL clear on IDLE->RUN.
REQ-021 mem_rd SHALL assert in RUN only, when reads remain and (fifo_count + in_flight - pop) < 2.
REQ-022 Read data SHALL be written into a 2-entry FIFO on the cycle it is valid; the FIFO head drives pix_data and pix_valid=!empty.
REQ-023 Latency: start in cycle 0 -> mem_rd with addr 0 in cycle 1 -> pix_valid with pixel 0 in cycle 3.
REQ-024 With eng_busy held 0, throughput SHALL be 1 beat per cycle; a full frame SHALL complete with done in cycle IMG_W*IMG_H+3.
REQ-025 While eng_busy=1, pix_data and pix_valid SHALL hold stable; no pixel SHALL be dropped or duplicated; the FIFO SHALL never overflow.
REQ-026 Simultaneous FIFO push and pop SHALL leave the count unchanged and preserve order.
REQ-027 When not pix_valid, pix_data SHALL be 0, never X or Z.
REQ-028 Transmit counter SHALL count accepted beats; it SHALL be 0 in IDLE.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, FIFO empty, both counters 0, in_flight 0.
REQ-030 Output reset values: mem_rd=0, mem_addr=0, pix_valid=0, pix_data=0, feeding=0, done=0.
REQ-031 rst mid-frame SHALL abort the frame with no done pulse; a read returning after reset is released SHALL be discarded.
REQ-032 First start after reset release SHALL produce a complete, correct frame.

Structure
REQ-033 IMG_W, IMG_H, PIX_W, the frame size constant and the state enum SHALL live in shared package sede_pkg, which the edge engine also uses.
REQ-034 The 2-entry FIFO SHALL be sub-module pix_skid_fifo (push, pop, din, dout, empty, count).

Verification
REQ-035 Memory[a]=a mod 256, eng_busy=0, start pulse -> 1024 beats with values 0,1,..,255,0,.. in consecutive cycles; first beat in cycle 3; done one pulse in cycle 1027.
REQ-036 eng_busy=1 for cycles 10-19 -> pix_data frozen at the value shown in cycle 10; sequence continues without gap or repeat; done delayed 10 cycles.
REQ-037 eng_busy toggled pseudo-randomly at 50% -> exactly 1024 accepted beats in address order; FIFO count never exceeds 2.
REQ-038 start re-pulsed in cycle 100 of a frame -> ignored; still exactly 1024 beats and one done.
REQ-039 rst asserted in cycle 500, released in cycle 503, start in cycle 510 -> no done before 510; new frame starts at pixel 0 with full 1024 beats.
REQ-040 Back-to-back frames, start in the cycle after done -> second frame identical to the first; feeding low for at least 1 cycle between frames.
